// File: rtl/clause_status_collector.sv
// Snapshots per-clause conflict/implication/satisfied status on start and serialises it
// into one valid/ready event stream (conflict first), followed by a done pulse and all-satisfied flag.
module clause_status_collector #(
    parameter int NUM_C     = 8,
    parameter int WIDTH_LVL = 16,
    parameter int WIDTH_CID = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [NUM_C-1:0]           conflict_c_drv_i,
    input  logic [NUM_C-1:0]           imp_drv_i,
    input  logic [NUM_C-1:0]           csat_drv_i,
    input  logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [1:0]                 evt_type_o,
    output logic [WIDTH_CID-1:0]       evt_cid_o,
    output logic [WIDTH_LVL-1:0]       evt_lvl_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       all_sat_o
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t                     state, state_n;
    logic [NUM_C-1:0]           conf_pend, imp_pend, conf_n, imp_n;
    logic [NUM_C*WIDTH_LVL-1:0] lvl_snap, lvl_n;
    logic                       sat_snap, sat_n;
    logic                       valid_n, busy_n, done_n, all_sat_n;
    logic [1:0]                 type_n;
    logic [WIDTH_CID-1:0]       cid_n;
    logic [WIDTH_LVL-1:0]       evt_lvl_n;

    function automatic logic [WIDTH_CID-1:0] lowest(input logic [NUM_C-1:0] v);
        lowest = '0;
        for (int k = NUM_C - 1; k >= 0; k--) begin
            if (v[k]) lowest = WIDTH_CID'(k);
        end
    endfunction

    // Outputs are computed from the next-cycle masks so the following event appears
    // the cycle right after an acceptance, with no bubble.
    always_comb begin
        state_n   = state;
        conf_n    = conf_pend;
        imp_n     = imp_pend;
        lvl_n     = lvl_snap;
        sat_n     = sat_snap;
        all_sat_n = all_sat_o;
        type_n    = 2'b00;
        cid_n     = '0;
        evt_lvl_n = '0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    conf_n    = conflict_c_drv_i;
                    imp_n     = imp_drv_i;
                    lvl_n     = cmax_lvl_i;
                    sat_n     = &csat_drv_i;
                    all_sat_n = 1'b0;
                    state_n   = EMIT;
                end
            end
            EMIT: begin
                if (evt_valid_o && evt_ready_i) begin
                    if (evt_type_o == 2'b10) begin
                        conf_n = '0;
                        imp_n  = '0;
                    end else begin
                        imp_n[evt_cid_o] = 1'b0;
                    end
                end
                if (conf_n == '0 && imp_n == '0) begin
                    state_n   = DONE;
                    all_sat_n = sat_snap;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        valid_n = (state_n == EMIT) && ((|conf_n) || (|imp_n));
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);

        if (valid_n) begin
            if (|conf_n) begin
                type_n = 2'b10;
                cid_n  = lowest(conf_n);
            end else begin
                type_n = 2'b01;
                cid_n  = lowest(imp_n);
            end
            evt_lvl_n = lvl_n[int'(cid_n)*WIDTH_LVL +: WIDTH_LVL];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            conf_pend   <= '0;
            imp_pend    <= '0;
            lvl_snap    <= '0;
            sat_snap    <= 1'b0;
            evt_valid_o <= 1'b0;
            evt_type_o  <= 2'b00;
            evt_cid_o   <= '0;
            evt_lvl_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            all_sat_o   <= 1'b0;
        end else begin
            state       <= state_n;
            conf_pend   <= conf_n;
            imp_pend    <= imp_n;
            lvl_snap    <= lvl_n;
            sat_snap    <= sat_n;
            evt_valid_o <= valid_n;
            evt_type_o  <= type_n;
            evt_cid_o   <= cid_n;
            evt_lvl_o   <= evt_lvl_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
            all_sat_o   <= all_sat_n;
        end
    end

endmodule
